// File: rtl/chimera_cluster_pwr_seq_if.sv
// Control bundle between the config-register enables, the per-cluster
// axi_isolate handshakes and the cluster power/clock/reset controls.
interface chimera_cluster_pwr_seq_if #(
   parameter int unsigned NumClusters = 5
);
   logic [NumClusters-1:0] en_req_i;
   logic [NumClusters-1:0] isolated_i;
   logic [NumClusters-1:0] timeout_clr_i;
   logic [NumClusters-1:0] isolate_o;
   logic [NumClusters-1:0] clk_en_o;
   logic [NumClusters-1:0] clu_rst_no;
   logic [NumClusters-1:0] on_o;
   logic [NumClusters-1:0] busy_o;
   logic [NumClusters-1:0] timeout_o;

   modport master (
      input  en_req_i,
      input  isolated_i,
      input  timeout_clr_i,
      output isolate_o,
      output clk_en_o,
      output clu_rst_no,
      output on_o,
      output busy_o,
      output timeout_o
   );

   modport slave (
      output en_req_i,
      output isolated_i,
      output timeout_clr_i,
      input  isolate_o,
      input  clk_en_o,
      input  clu_rst_no,
      input  on_o,
      input  busy_o,
      input  timeout_o
   );
endinterface

// File: rtl/chimera_cluster_pwr_seq.sv
// Per-cluster power sequencer: orders AXI isolation, clock gating and
// cluster reset so no cluster is gated or reset with traffic in flight.
module chimera_cluster_pwr_seq #(
   parameter int unsigned NumClusters   = 5,
   parameter int unsigned RstHoldCycles = 16,
   parameter int unsigned IsoTimeout    = 1024
) (
   input logic                       clk_i,
   input logic                       rst_ni,
   chimera_cluster_pwr_seq_if.master bus
);

   localparam int unsigned CntMax =
      (RstHoldCycles > IsoTimeout) ? RstHoldCycles : IsoTimeout;
   localparam int unsigned CntW = $clog2(CntMax + 1);

   localparam logic [CntW-1:0] RstLoad = CntW'(RstHoldCycles - 1);
   localparam logic [CntW-1:0] IsoLast =
      CntW'((IsoTimeout > 0) ? IsoTimeout - 1 : 0);
   localparam bit TimeoutEn = (IsoTimeout > 0);

   typedef enum logic [2:0] {
      StOff,
      StPwrup,
      StDeiso,
      StOn,
      StIso,
      StRsta
   } state_e;

   state_e          state_q [NumClusters];
   state_e          state_d [NumClusters];
   logic [CntW-1:0] cnt_q   [NumClusters];
   logic [CntW-1:0] cnt_d   [NumClusters];

   logic [NumClusters-1:0] timeout_q;
   logic [NumClusters-1:0] timeout_d;

   logic [NumClusters-1:0] iso;
   logic [NumClusters-1:0] cke;
   logic [NumClusters-1:0] rstn;
   logic [NumClusters-1:0] on;
   logic [NumClusters-1:0] busy;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < NumClusters; i++) begin
            state_q[i] <= StOff;
            cnt_q[i]   <= '0;
         end
         timeout_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   logic   hs_ok;
   state_e hs_next;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      timeout_d = timeout_q & ~bus.timeout_clr_i;
      hs_ok     = 1'b0;
      hs_next   = StOff;
      for (int i = 0; i < NumClusters; i++) begin
         unique case (state_q[i])
            StOff: begin
               if (bus.en_req_i[i]) begin
                  state_d[i] = StPwrup;
                  cnt_d[i]   = RstLoad;
               end
            end
            StPwrup: begin
               if (cnt_q[i] == '0) begin
                  state_d[i] = StDeiso;
                  cnt_d[i]   = '0;
               end else begin
                  cnt_d[i] = cnt_q[i] - CntW'(1);
               end
            end
            StDeiso, StIso: begin
               // Both waits share one handshake/timeout path; only the
               // expected isolated_i level and the successor differ.
               if (state_q[i] == StDeiso) begin
                  hs_ok   = !bus.isolated_i[i];
                  hs_next = StOn;
               end else begin
                  hs_ok   = bus.isolated_i[i];
                  hs_next = StRsta;
               end
               if (hs_ok) begin
                  state_d[i] = hs_next;
               end else if (TimeoutEn && (cnt_q[i] == IsoLast)) begin
                  state_d[i]   = hs_next;
                  timeout_d[i] = 1'b1;
               end else if (TimeoutEn) begin
                  cnt_d[i] = cnt_q[i] + CntW'(1);
               end
            end
            StOn: begin
               if (!bus.en_req_i[i]) begin
                  state_d[i] = StIso;
                  cnt_d[i]   = '0;
               end
            end
            StRsta: begin
               state_d[i] = StOff;
            end
            default: begin
               state_d[i] = StOff;
            end
         endcase
      end
   end

   // Moore decode: reset drops in RSTA while the clock still runs.
   always_comb begin
      iso  = '1;
      cke  = '0;
      rstn = '0;
      on   = '0;
      busy = '0;
      for (int i = 0; i < NumClusters; i++) begin
         unique case (state_q[i])
            StOff:   {iso[i], cke[i], rstn[i], on[i], busy[i]} = 5'b10000;
            StPwrup: {iso[i], cke[i], rstn[i], on[i], busy[i]} = 5'b11001;
            StDeiso: {iso[i], cke[i], rstn[i], on[i], busy[i]} = 5'b01101;
            StOn:    {iso[i], cke[i], rstn[i], on[i], busy[i]} = 5'b01110;
            StIso:   {iso[i], cke[i], rstn[i], on[i], busy[i]} = 5'b11101;
            StRsta:  {iso[i], cke[i], rstn[i], on[i], busy[i]} = 5'b11001;
            default: {iso[i], cke[i], rstn[i], on[i], busy[i]} = 5'b10000;
         endcase
      end
   end

   assign bus.isolate_o  = iso;
   assign bus.clk_en_o   = cke;
   assign bus.clu_rst_no = rstn;
   assign bus.on_o       = on;
   assign bus.busy_o     = busy;
   assign bus.timeout_o  = timeout_q;

endmodule

// File: tb/tb_chimera_cluster_pwr_seq.sv
// Bench for chimera_cluster_pwr_seq: directed latency scenarios plus
// randomized traffic checked against a phase/elapsed-time reference model.
module tb_chimera_cluster_pwr_seq;

   localparam int N  = 5;
   localparam int RH = 16;
   localparam int TO = 8;

   localparam int P_OFF   = 0;
   localparam int P_PWRUP = 1;
   localparam int P_DEISO = 2;
   localparam int P_ON    = 3;
   localparam int P_ISO   = 4;
   localparam int P_RSTA  = 5;

   localparam logic [6*N-1:0] RST_OBS = {{N{1'b1}}, {(5*N){1'b0}}};

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   int          ph   [N];
   int          age  [N];
   bit          mto  [N];
   int          mode [N];
   int          lag  [N];
   logic [15:0] hist [N];

   chimera_cluster_pwr_seq_if #(.NumClusters(N)) bus ();

   chimera_cluster_pwr_seq #(
      .NumClusters  (N),
      .RstHoldCycles(RH),
      .IsoTimeout   (TO)
   ) dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   // iso clk rst_n on busy for each phase
   function automatic logic [4:0] row(input int p);
      case (p)
         P_PWRUP: return 5'b11001;
         P_DEISO: return 5'b01101;
         P_ON:    return 5'b01110;
         P_ISO:   return 5'b11101;
         P_RSTA:  return 5'b11001;
         default: return 5'b10000;
      endcase
   endfunction

   function automatic logic [6*N-1:0] model_obs();
      logic [N-1:0] a, b, c, d, e, f;
      logic [4:0]   r;
      for (int i = 0; i < N; i++) begin
         r = row(ph[i]);
         {a[i], b[i], c[i], d[i], e[i]} = r;
         f[i] = mto[i];
      end
      return {a, b, c, d, e, f};
   endfunction

   function automatic logic [6*N-1:0] dut_obs();
      return {bus.isolate_o, bus.clk_en_o, bus.clu_rst_no,
              bus.on_o, bus.busy_o, bus.timeout_o};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         ph[i]   = P_OFF;
         age[i]  = 0;
         mto[i]  = 1'b0;
         mode[i] = 0;
         lag[i]  = 2;
         hist[i] = '1;
      end
   endtask

   task automatic model_step();
      int np;
      bit en, hs, set;
      for (int i = 0; i < N; i++) begin
         np  = ph[i];
         en  = bus.en_req_i[i];
         hs  = bus.isolated_i[i];
         set = 1'b0;
         case (ph[i])
            P_OFF:   if (en) np = P_PWRUP;
            P_PWRUP: if (age[i] + 1 == RH) np = P_DEISO;
            P_DEISO: begin
               if (!hs) np = P_ON;
               else if (age[i] + 1 == TO) begin np = P_ON; set = 1'b1; end
            end
            P_ON:    if (!en) np = P_ISO;
            P_ISO: begin
               if (hs) np = P_RSTA;
               else if (age[i] + 1 == TO) begin np = P_RSTA; set = 1'b1; end
            end
            default: np = P_OFF;
         endcase
         if (set) mto[i] = 1'b1;
         else if (bus.timeout_clr_i[i]) mto[i] = 1'b0;
         age[i] = (np == ph[i]) ? age[i] + 1 : 0;
         ph[i]  = np;
      end
   endtask

   // Emulated axi_isolate: isolated_i follows isolate with a per-cluster lag.
   task automatic drive_hs();
      logic [4:0] r;
      for (int i = 0; i < N; i++) begin
         r       = row(ph[i]);
         hist[i] = {hist[i][14:0], r[4]};
         case (mode[i])
            1:       bus.isolated_i[i] = 1'b0;
            2:       bus.isolated_i[i] = 1'b1;
            default: bus.isolated_i[i] = hist[i][lag[i]];
         endcase
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst_n) model_step();
      cyc++;
      @(negedge clk);
      drive_hs();
   endtask

   task automatic do_reset();
      bus.en_req_i      = '0;
      bus.timeout_clr_i = '0;
      bus.isolated_i    = '1;
      rst_n             = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      cyc   = 0;
   endtask

   task automatic test_reset();
      do_reset();
      n_tests++;
      if (dut_obs() !== RST_OBS) begin
         n_fail++;
         $display("FAIL reset_values: got %h want %h", dut_obs(), RST_OBS);
      end
      for (int k = 0; k < 4; k++) begin
         tick();
         n_tests++;
         if (dut_obs() !== RST_OBS) begin
            n_fail++;
            $display("FAIL reset_idle: got %h want %h", dut_obs(), RST_OBS);
         end
      end
   endtask

   task automatic test_powerup();
      int c0;
      int t_clk = -1, t_rst = -1, t_on = -1;
      do_reset();
      c0 = cyc;
      bus.en_req_i[0] = 1'b1;
      for (int k = 0; k < 30; k++) begin
         tick();
         n_tests++;
         if (dut_obs() !== model_obs()) begin
            n_fail++;
            $display("FAIL powerup_c%0d: got %h want %h",
                     cyc - c0, dut_obs(), model_obs());
         end
         if (t_clk < 0 && bus.clk_en_o[0]) t_clk = cyc - c0;
         if (t_rst < 0 && bus.clu_rst_no[0] && !bus.isolate_o[0])
            t_rst = cyc - c0;
         if (t_on < 0 && bus.on_o[0]) t_on = cyc - c0;
      end
      n_tests++;
      if (t_clk !== 1) begin
         n_fail++;
         $display("FAIL powerup_clk_en_cycle: got %0d want 1", t_clk);
      end
      n_tests++;
      if (t_rst !== 1 + RH) begin
         n_fail++;
         $display("FAIL powerup_release_cycle: got %0d want %0d", t_rst, 1 + RH);
      end
      n_tests++;
      if (t_on !== 20) begin
         n_fail++;
         $display("FAIL powerup_on_cycle: got %0d want 20", t_on);
      end
   endtask

   task automatic test_powerdown();
      int t;
      int t_iso = -1, t_rst = -1, clk_off = -1, busy_off = -1;
      lag[0] = 4;
      t = cyc;
      bus.en_req_i[0] = 1'b0;
      for (int k = 0; k < 12; k++) begin
         tick();
         n_tests++;
         if (dut_obs() !== model_obs()) begin
            n_fail++;
            $display("FAIL powerdown_t+%0d: got %h want %h",
                     cyc - t, dut_obs(), model_obs());
         end
         if (t_iso < 0 && bus.isolate_o[0]) t_iso = cyc - t;
         if (t_rst < 0 && !bus.clu_rst_no[0]) t_rst = cyc - t;
         if (bus.clk_en_o[0]) clk_off = cyc - t + 1;
         if (bus.busy_o[0]) busy_off = cyc - t + 1;
      end
      n_tests++;
      if (t_iso !== 1) begin
         n_fail++;
         $display("FAIL powerdown_isolate_cycle: got %0d want 1", t_iso);
      end
      n_tests++;
      if (t_rst !== 6) begin
         n_fail++;
         $display("FAIL powerdown_reset_cycle: got %0d want 6", t_rst);
      end
      n_tests++;
      if (clk_off !== 7) begin
         n_fail++;
         $display("FAIL powerdown_clk_gate_cycle: got %0d want 7", clk_off);
      end
      n_tests++;
      if (busy_off !== 7) begin
         n_fail++;
         $display("FAIL powerdown_busy_clear_cycle: got %0d want 7", busy_off);
      end
   endtask

   task automatic test_timeout();
      int t;
      int t_to = -1;
      do_reset();
      lag[1] = 1;
      bus.en_req_i[1] = 1'b1;
      for (int k = 0; k < 25; k++) begin
         tick();
         n_tests++;
         if (dut_obs() !== model_obs()) begin
            n_fail++;
            $display("FAIL timeout_up_c%0d: got %h want %h",
                     cyc, dut_obs(), model_obs());
         end
      end
      mode[1] = 1;
      t = cyc;
      bus.en_req_i[1] = 1'b0;
      for (int k = 0; k < 15; k++) begin
         tick();
         n_tests++;
         if (dut_obs() !== model_obs()) begin
            n_fail++;
            $display("FAIL timeout_down_t+%0d: got %h want %h",
                     cyc - t, dut_obs(), model_obs());
         end
         if (t_to < 0 && bus.timeout_o[1]) t_to = cyc - t;
      end
      n_tests++;
      if (t_to !== 1 + TO) begin
         n_fail++;
         $display("FAIL timeout_set_cycle: got %0d want %0d", t_to, 1 + TO);
      end
      n_tests++;
      if ({bus.clk_en_o[1], bus.busy_o[1]} !== 2'b00) begin
         n_fail++;
         $display("FAIL timeout_reaches_off: got %b want 00",
                  {bus.clk_en_o[1], bus.busy_o[1]});
      end
   endtask

   task automatic test_timeout_clr();
      int c0;
      int t_on = -1;
      logic to_at_on = 1'b0;
      repeat (3) tick();
      n_tests++;
      if (bus.timeout_o[1] !== 1'b1) begin
         n_fail++;
         $display("FAIL timeout_sticky: got %b want 1", bus.timeout_o[1]);
      end
      bus.timeout_clr_i[1] = 1'b1;
      tick();
      bus.timeout_clr_i[1] = 1'b0;
      n_tests++;
      if (bus.timeout_o[1] !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_clear: got %b want 0", bus.timeout_o[1]);
      end
      // clear held high while a DEISO timeout fires: the set must win
      mode[1] = 2;
      bus.timeout_clr_i[1] = 1'b1;
      bus.en_req_i[1] = 1'b1;
      c0 = cyc;
      for (int k = 0; k < 30; k++) begin
         tick();
         n_tests++;
         if (dut_obs() !== model_obs()) begin
            n_fail++;
            $display("FAIL timeout_prio_c%0d: got %h want %h",
                     cyc - c0, dut_obs(), model_obs());
         end
         if (t_on < 0 && bus.on_o[1]) begin
            t_on     = cyc - c0;
            to_at_on = bus.timeout_o[1];
         end
      end
      bus.timeout_clr_i[1] = 1'b0;
      n_tests++;
      if (t_on !== 1 + RH + TO) begin
         n_fail++;
         $display("FAIL timeout_deiso_on_cycle: got %0d want %0d",
                  t_on, 1 + RH + TO);
      end
      n_tests++;
      if (to_at_on !== 1'b1) begin
         n_fail++;
         $display("FAIL timeout_set_over_clr: got %b want 1", to_at_on);
      end
   endtask

   task automatic test_toggle();
      int c0;
      int t_on = -1, on_cnt = 0;
      do_reset();
      c0 = cyc;
      bus.en_req_i[3] = 1'b1;
      for (int k = 0; k < 40; k++) begin
         tick();
         if (k == 2) bus.en_req_i[3] = 1'b0;
         n_tests++;
         if (dut_obs() !== model_obs()) begin
            n_fail++;
            $display("FAIL toggle_c%0d: got %h want %h",
                     cyc - c0, dut_obs(), model_obs());
         end
         if (bus.on_o[3]) begin
            on_cnt++;
            if (t_on < 0) t_on = cyc - c0;
         end
      end
      n_tests++;
      if (t_on !== 20 || on_cnt !== 1) begin
         n_fail++;
         $display("FAIL toggle_on_pulse: got c%0d x%0d want c20 x1",
                  t_on, on_cnt);
      end
      n_tests++;
      if ({bus.clk_en_o[3], bus.busy_o[3]} !== 2'b00) begin
         n_fail++;
         $display("FAIL toggle_back_off: got %b want 00",
                  {bus.clk_en_o[3], bus.busy_o[3]});
      end
   endtask

   task automatic test_async_reset();
      int c0;
      int t_clk = -1, t_on = -1;
      do_reset();
      bus.en_req_i[0] = 1'b1;
      repeat (1 + RH) tick();
      n_tests++;
      if (bus.isolate_o[0] !== 1'b0 || bus.busy_o[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL async_in_deiso: got iso=%b busy=%b want iso=0 busy=1",
                  bus.isolate_o[0], bus.busy_o[0]);
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (dut_obs() !== RST_OBS) begin
         n_fail++;
         $display("FAIL async_reset_values: got %h want %h", dut_obs(), RST_OBS);
      end
      do_reset();
      c0 = cyc;
      bus.en_req_i[0] = 1'b1;
      for (int k = 0; k < 25; k++) begin
         tick();
         n_tests++;
         if (dut_obs() !== model_obs()) begin
            n_fail++;
            $display("FAIL async_reup_c%0d: got %h want %h",
                     cyc - c0, dut_obs(), model_obs());
         end
         if (t_clk < 0 && bus.clk_en_o[0]) t_clk = cyc - c0;
         if (t_on < 0 && bus.on_o[0]) t_on = cyc - c0;
      end
      n_tests++;
      if (t_clk !== 1 || t_on !== 20) begin
         n_fail++;
         $display("FAIL async_reup_timing: got clk c%0d on c%0d want c1 c20",
                  t_clk, t_on);
      end
   endtask

   task automatic test_independence();
      int c0;
      int t_on0 = -1, t_on4 = -1, t_clk0 = -1, t_clk4 = -1;
      do_reset();
      bus.en_req_i[2] = 1'b1;
      repeat (25) tick();
      c0 = cyc;
      bus.en_req_i[0] = 1'b1;
      bus.en_req_i[4] = 1'b1;
      for (int k = 0; k < 30; k++) begin
         tick();
         if (k == 7) bus.en_req_i[2] = 1'b0;
         n_tests++;
         if (dut_obs() !== model_obs()) begin
            n_fail++;
            $display("FAIL indep_c%0d: got %h want %h",
                     cyc - c0, dut_obs(), model_obs());
         end
         if (t_clk0 < 0 && bus.clk_en_o[0]) t_clk0 = cyc - c0;
         if (t_clk4 < 0 && bus.clk_en_o[4]) t_clk4 = cyc - c0;
         if (t_on0 < 0 && bus.on_o[0]) t_on0 = cyc - c0;
         if (t_on4 < 0 && bus.on_o[4]) t_on4 = cyc - c0;
      end
      n_tests++;
      if (t_clk0 !== 1 || t_clk4 !== 1 || t_on0 !== 20 || t_on4 !== 20) begin
         n_fail++;
         $display("FAIL indep_lockstep: got %0d/%0d/%0d/%0d want 1/1/20/20",
                  t_clk0, t_clk4, t_on0, t_on4);
      end
      n_tests++;
      if (bus.clk_en_o[2] !== 1'b0) begin
         n_fail++;
         $display("FAIL indep_c2_off: got %b want 0", bus.clk_en_o[2]);
      end
   endtask

   task automatic test_random();
      int errs = 0;
      do_reset();
      for (int i = 0; i < N; i++) lag[i] = $urandom_range(0, 10);
      for (int k = 0; k < 2000; k++) begin
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 39) == 0)
               bus.en_req_i[i] = ~bus.en_req_i[i];
            bus.timeout_clr_i[i] = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 199) == 0) begin
               lag[i]  = $urandom_range(0, 10);
               mode[i] = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 2) : 0;
            end
         end
         tick();
         n_tests++;
         if (dut_obs() !== model_obs()) begin
            n_fail++;
            errs++;
            if (errs <= 10)
               $display("FAIL random_c%0d: got %h want %h",
                        cyc, dut_obs(), model_obs());
         end
      end
   endtask

   initial begin
      bus.en_req_i      = '0;
      bus.isolated_i    = '1;
      bus.timeout_clr_i = '0;
      test_reset();
      test_powerup();
      test_powerdown();
      test_timeout();
      test_timeout_clr();
      test_toggle();
      test_async_reset();
      test_independence();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
